fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS datapath, directly upstream of the instruction decoder/controller. Maintains the program counter, issues single-outstanding word requests to instruction memory, buffers returned instructions in a 2-entry queue, and presents them to decode with a valid/ready handshake. A jump-register redirect from the execute side flushes the queue and restarts fetch at the new target.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, 2-entry instruction queue.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets latch misalign_err and halt fetch.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] WAIT    = 2'd1;
   localparam logic [1:0] DISCARD = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [1:0]  count;
   logic [31:0] head_pc, head_word, tail_pc, tail_word;
   logic [31:0] target;
   logic        halted;
   logic        push;
   logic        pop;

`ifdef FETCH_ALIGN_CHECK_EN
   assign target = redirect_pc;

   // Once a misaligned target is seen, fetch stays stopped until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         halted <= 1'b0;
      else if (redirect && (redirect_pc[1:0] != 2'b00))
         halted <= 1'b1;
   end

   assign misalign_err = halted;
`else
   assign target       = redirect_pc & 32'hFFFF_FFFC;
   assign halted       = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Issue depends on count (a register), never directly on instr_ready.
   assign imem_req    = !rst && (state == IDLE) && (count != 2'd2) && !halted && !redirect;
   assign imem_addr   = pc;
   assign instr_valid = (count != 2'd0);
   assign instr       = head_word;
   assign instr_pc    = head_pc;

   assign push = (state == WAIT) && imem_rvalid && !redirect;
   assign pop  = instr_valid && instr_ready && !redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         req_pc <= 32'd0;
         count  <= 2'd0;
      end else if (redirect) begin
         pc    <= target;
         count <= 2'd0;
         if ((state != IDLE) && imem_rvalid)
            state <= IDLE;
         else if (state == WAIT)
            state <= DISCARD;
      end else begin
         if (imem_req) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= WAIT;
         end else if ((state != IDLE) && imem_rvalid) begin
            state <= IDLE;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head always holds the oldest entry; the tail shifts forward on a pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_pc   <= 32'd0;
         head_word <= 32'd0;
         tail_pc   <= 32'd0;
         tail_word <= 32'd0;
      end else begin
         if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            head_pc   <= req_pc;
            head_word <= imem_rdata;
         end else if (pop) begin
            head_pc   <= tail_pc;
            head_word <= tail_word;
         end
         if (push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) begin
            tail_pc   <= req_pc;
            tail_word <= imem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory plus an expected-pc scoreboard.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        misalign_err;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .misalign_err(misalign_err)
   );

   typedef struct {
      logic [31:0] target;
      logic [31:0] exp_addr;
      logic [31:0] exp_next;
      logic        exp_err;
   } redir_vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cycle = 0;
   int          mem_lat = 1;
   logic        mem_pend = 1'b0;
   int          mem_wait = 0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] exp_q[$];
   logic [31:0] req_log[$];
   int          req_cyc[$];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic noteFail(input string name, input logic [31:0] act);
      n_cmp++;
      n_err++;
      $display("[TB] FAIL %s: got %h, no value expected", name, act);
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // Instruction memory: answers each request after mem_lat cycles with an address-tagged word.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         imem_rvalid = 1'b0;
         if (rst) begin
            mem_pend = 1'b0;
         end else begin
            if (mem_pend) begin
               mem_wait--;
               if (mem_wait == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = word_of(mem_addr);
                  mem_pend    = 1'b0;
               end
            end
            if (imem_req) begin
               if (mem_pend) noteFail("second_outstanding_req", imem_addr);
               mem_pend = 1'b1;
               mem_wait = mem_lat;
               mem_addr = imem_addr;
               req_log.push_back(imem_addr);
               req_cyc.push_back(cycle);
            end
         end
      end
   end

   // Scoreboard: every decode handshake pops the oldest expected pc.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
               noteFail("unexpected_instr_pc", instr_pc);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               checkOutput("instr_pc", instr_pc, e);
               checkOutput("instr", instr, word_of(e));
            end
         end
      end
   end

   task automatic applyReset();
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      instr_ready = 1'b0;
      @(negedge clk);
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
      checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_instr_pc", instr_pc, 32'd0);
      checkOutput("rst_misalign_err", 32'(misalign_err), 32'd0);
      exp_q.delete();
      req_log.delete();
      req_cyc.delete();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic waitReqs(input int n, input int budget);
      for (int i = 0; i < budget && req_log.size() < n; i++) begin
         @(posedge clk);
         #1;
      end
      if (req_log.size() < n) noteFail("req_timeout", 32'(req_log.size()));
   endtask

   task automatic waitDrain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         noteFail("drain_timeout", 32'(exp_q.size()));
         exp_q.delete();
      end
      instr_ready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      @(posedge clk);
      #1 redirect = 1'b0;
   endtask

   initial begin
      redir_vec_t vecs[4];
      vecs[0] = '{target: 32'h0000_0100, exp_addr: 32'h0000_0100, exp_next: 32'h0000_0104, exp_err: 1'b0};
      vecs[1] = '{target: 32'h0000_2A40, exp_addr: 32'h0000_2A40, exp_next: 32'h0000_2A44, exp_err: 1'b0};
      vecs[2] = '{target: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, exp_next: 32'h0000_0000, exp_err: 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
      vecs[3] = '{target: 32'h0000_0102, exp_addr: 32'h0000_0000, exp_next: 32'h0000_0000, exp_err: 1'b1};
`else
      vecs[3] = '{target: 32'h0000_0102, exp_addr: 32'h0000_0100, exp_next: 32'h0000_0104, exp_err: 1'b0};
`endif

      // Streaming with zero-wait memory: one instruction every two cycles.
      applyReset();
      mem_lat     = 1;
      instr_ready = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      waitDrain(40);
      waitReqs(4, 10);
      if (req_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput("stream_addr", req_log[i], 32'(i * 4));
            if (i > 0) checkOutput("stream_spacing", 32'(req_cyc[i] - req_cyc[i-1]), 32'd2);
         end
      end

      // Backpressure: queue fills to two entries and requests stop.
      applyReset();
      mem_lat = 1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("bp_req_count", 32'(req_log.size()), 32'd2);
      checkOutput("bp_imem_req", 32'(imem_req), 32'd0);
      checkOutput("bp_valid", 32'(instr_valid), 32'd1);
      checkOutput("bp_head_pc", instr_pc, 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      instr_ready = 1'b1;
      waitDrain(40);

      // Redirect while a request is outstanding; the stale response lands two cycles later.
      foreach (vecs[k]) begin
         applyReset();
         mem_lat     = 3;
         instr_ready = 1'b1;
         exp_q.push_back(32'h0);
         waitReqs(2, 20);
         applyStimulus(vecs[k].target);
         if (vecs[k].exp_err) begin
            repeat (12) @(posedge clk);
            @(negedge clk);
            checkOutput("halt_req_count", 32'(req_log.size()), 32'd2);
            checkOutput("halt_imem_req", 32'(imem_req), 32'd0);
            checkOutput("halt_misalign_err", 32'(misalign_err), 32'd1);
            checkOutput("halt_valid", 32'(instr_valid), 32'd0);
            checkOutput("halt_pending", 32'(exp_q.size()), 32'd0);
            @(posedge clk);
            #1 instr_ready = 1'b0;
         end else begin
            exp_q.push_back(vecs[k].exp_addr);
            exp_q.push_back(vecs[k].exp_next);
            waitDrain(60);
            if (req_log.size() >= 3) checkOutput("redir_addr", req_log[2], vecs[k].exp_addr);
            else noteFail("redir_no_req", 32'(req_log.size()));
            checkOutput("redir_misalign_err", 32'(misalign_err), 32'd0);
         end
      end

      // Redirect coinciding with a response and a head handshake.
      applyReset();
      mem_lat = 1;
      waitReqs(2, 20);
      exp_q.push_back(32'h0);
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      checkOutput("same_cycle_rvalid", 32'(imem_rvalid), 32'd1);
      @(posedge clk);
      #1;
      redirect    = 1'b0;
      instr_ready = 1'b0;
      @(negedge clk);
      checkOutput("same_cycle_delivered", 32'(exp_q.size()), 32'd0);
      checkOutput("same_cycle_valid", 32'(instr_valid), 32'd0);
      checkOutput("same_cycle_req", 32'(imem_req), 32'd1);
      checkOutput("same_cycle_addr", imem_addr, 32'h0000_0200);
      @(posedge clk);
      #1;
      exp_q.push_back(32'h0000_0200);
      instr_ready = 1'b1;
      waitDrain(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
